// File: rtl/pattern_tx_if.sv
//------------------------------------------------------------------------------
// pattern_tx_if : word handshake in, serial bit stream and status out
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pattern_tx_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             out;
    logic             out_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames;

    modport master (
        output data_in, valid,
        input  ready, out, out_en, busy, done, frames
    );

    modport slave (
        input  data_in, valid,
        output ready, out, out_en, busy, done, frames
    );
endinterface

`default_nettype wire

// File: rtl/pattern_tx.sv
//------------------------------------------------------------------------------
// pattern_tx : MSB-first serial transmitter with gapless back-to-back frames.
// Optional even-parity trailer bit when PARITY_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pattern_tx #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    pattern_tx_if.slave  bus
);
    localparam int BCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef PARITY_EN
        ,S_PAR  = 2'd2
`endif
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [BCW-1:0]   r_cnt;
    logic             r_out;
    logic             r_out_en;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_frames;
`ifdef PARITY_EN
    logic             r_par;
`endif
    logic             w_last;
    logic             w_hs;

    // r_cnt is the index of the data bit currently on out
    always_comb begin
`ifdef PARITY_EN
        w_last = (r_state == S_PAR);
`else
        w_last = (r_state == S_SHIFT) && (r_cnt == '0);
`endif
    end

    assign bus.ready  = (r_state == S_IDLE) || w_last;
    assign w_hs       = bus.valid && bus.ready;
    assign bus.out    = r_out;
    assign bus.out_en = r_out_en;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.frames = r_frames;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_out    <= 1'b0;
            r_out_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_frames <= '0;
`ifdef PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            if (r_done)
                r_frames <= r_frames + CNT_W'(1);

            if (w_hs) begin
                r_state  <= S_SHIFT;
                r_out    <= bus.data_in[WIDTH-1];
                r_sr     <= bus.data_in << 1;
                r_cnt    <= BCW'(WIDTH - 1);
                r_out_en <= 1'b1;
                r_busy   <= 1'b1;
`ifdef PARITY_EN
                r_par    <= ^bus.data_in;
                r_done   <= 1'b0;
`else
                r_done   <= (WIDTH == 1);
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_out    <= 1'b0;
                        r_out_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (r_cnt != '0) begin
                            r_out <= r_sr[WIDTH-1];
                            r_sr  <= r_sr << 1;
                            r_cnt <= r_cnt - BCW'(1);
`ifdef PARITY_EN
                            r_done <= 1'b0;
`else
                            r_done <= (r_cnt == BCW'(1));
`endif
                        end else begin
`ifdef PARITY_EN
                            r_state <= S_PAR;
                            r_out   <= r_par;
                            r_done  <= 1'b1;
`else
                            r_state  <= S_IDLE;
                            r_out    <= 1'b0;
                            r_out_en <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_out    <= 1'b0;
                        r_out_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_pattern_tx.sv
//------------------------------------------------------------------------------
// tb_pattern_tx : scoreboard bench, bit-stream model vs pattern_tx output
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pattern_tx;
    localparam int W  = 3;
    localparam int CW = 4;
`ifdef PARITY_EN
    localparam int FL = W + 1;
    localparam bit HAS_PAR = 1'b1;
`else
    localparam int FL = W;
    localparam bit HAS_PAR = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pending = 0;
    int   done_cnt = 0;
    bit   last_hs = 1'b0;
    logic [CW-1:0] frames_m = '0;
    exp_t exp_q[$];

    pattern_tx_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    pattern_tx #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame occupies FL consecutive cycles; a new word is taken
    // when at most the final bit of the current frame remains.
    always @(posedge clk) begin
        if (reset) begin
            automatic bit hs = bus.valid && (pending <= 1);
            automatic logic [W-1:0] d = bus.data_in;
            if (pending == 1) frames_m = frames_m + 1'b1;
            if (pending > 0) pending--;
            if (hs) begin
                pending += FL;
                for (int i = W - 1; i >= 0; i--)
                    exp_q.push_back('{b: d[i], last: (i == 0) && !HAS_PAR});
                if (HAS_PAR) exp_q.push_back('{b: ^d, last: 1'b1});
            end
            last_hs = hs;
        end
    end

    always @(negedge reset) begin
        pending  = 0;
        frames_m = '0;
        exp_q.delete();
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("ready", 32'(bus.ready), 32'(pending <= 1));
            chk("out_en", 32'(bus.out_en), 32'(pending > 0));
            chk("busy", 32'(bus.busy), 32'(pending > 0));
            chk("frames", 32'(bus.frames), 32'(frames_m));
            if (bus.out_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'(1), 32'(0));
                end else begin
                    automatic exp_t e = exp_q.pop_front();
                    chk("out", 32'(bus.out), 32'(e.b));
                    chk("done", 32'(bus.done), 32'(e.last));
                    if (bus.done === 1'b1) done_cnt++;
                end
            end else begin
                chk("idle_out", 32'(bus.out), 32'(0));
                chk("idle_done", 32'(bus.done), 32'(0));
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.valid   = 1'b1;
            bus.data_in = d;
            @(posedge clk);
            #1;
            if (last_hs) return;
        end
        chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int d0;
        bus.valid   = 1'b0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'(1));
        chk("rst_out", 32'(bus.out), 32'(0));
        chk("rst_out_en", 32'(bus.out_en), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_frames", 32'(bus.frames), 32'(0));
        @(negedge clk);
        reset = 1'b1;

        // single frame
        send(3'b110);
        idle(FL + 2);
        chk("single_frames", 32'(bus.frames), 32'(1));

        // back-to-back with valid held
        d0 = done_cnt;
        send(3'b110);
        send(3'b110);
        idle(2 * FL + 2);
        chk("b2b_frames", 32'(bus.frames), 32'(3));
        chk("b2b_done_pulses", 32'(done_cnt - d0), 32'(2));

        // offer while busy is dropped
        send(3'b110);
        @(negedge clk);
        bus.valid = 1'b0;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.data_in = 3'b111;
        @(negedge clk);
        bus.valid = 1'b0;
        idle(FL + 2);
        chk("ignored_frames", 32'(bus.frames), 32'(4));

        // asynchronous abort mid-frame
        send(3'b110);
        @(negedge clk);
        bus.valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_out", 32'(bus.out), 32'(0));
        chk("abort_out_en", 32'(bus.out_en), 32'(0));
        chk("abort_frames", 32'(bus.frames), 32'(0));
        chk("abort_ready", 32'(bus.ready), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        send(3'b011);
        idle(FL + 2);
        chk("after_abort_frames", 32'(bus.frames), 32'(1));

        // parity-sensitive words
        send(3'b110);
        send(3'b100);
        idle(2 * FL + 2);
        chk("par_frames", 32'(bus.frames), 32'(3));

        // counter wrap
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) send(W'($urandom));
        idle(FL + 2);
        chk("wrap_15", 32'(bus.frames), 32'(15));
        send(3'b101);
        idle(FL + 2);
        chk("wrap_0", 32'(bus.frames), 32'(0));

        // random offers
        repeat (400) begin
            @(negedge clk);
            bus.valid   = 1'($urandom_range(0, 1));
            bus.data_in = W'($urandom);
        end
        idle(FL + 4);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
